// File: rtl/pwm_capture_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the PWM capture block.
// Also holds the loopback generator period so benches can line both sides up.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_STUCK   = 2'd2
   } cap_state_t;

   localparam int DUTY_W      = 8;
   localparam int GEN_PERIOD  = 256;
   localparam int TIMEOUT_DEF = 1024;

   function automatic logic [DUTY_W-1:0] sat_duty(input logic [31:0] v);
      return (v > 32'((1 << DUTY_W) - 1)) ? {DUTY_W{1'b1}} : v[DUTY_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_capture_sync_2ff.sv
`timescale 1ns/1ps
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, no backpressure.
// Both flops reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// Measures period, high time and 8-bit duty of an async PWM input, with stuck-level timeout.
// Results land one cycle after the synchronized rising edge; no backpressure, valid is a pulse.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pwm_in,
   output logic [CNT_W-1:0]  period_out,
   output logic [CNT_W-1:0]  high_out,
   output logic [DUTY_W-1:0] duty_out,
   output logic              valid,
   output logic              stuck,
   output logic              stuck_level
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             s2;
   logic             s3;
   logic [2:0]       prm;
   logic             rise;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hi_cnt;
   logic             seen_low;
   cap_state_t       state;
   cap_state_t       state_nxt;
   logic             ld_meas;
   logic             ld_stuck;
   logic             clr_stuck;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pwm_in),
      .q     (s2)
   );

   // prm tracks how far real samples have propagated past the reset zeros, so
   // a high level at reset release never looks like a low or a rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3  <= 1'b0;
         prm <= 3'b000;
      end else begin
         s3  <= s2;
         prm <= {prm[1:0], 1'b1};
      end
   end

   assign rise = s2 & ~s3 & prm[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt  <= '0;
         hi_cnt   <= '0;
         seen_low <= 1'b0;
      end else begin
         if (rise)
            per_cnt <= CNT_ONE;
         else if (per_cnt != CNT_MAX)
            per_cnt <= per_cnt + CNT_ONE;

         if (rise)
            hi_cnt <= CNT_ONE;
         else if (s2 && hi_cnt != CNT_MAX)
            hi_cnt <= hi_cnt + CNT_ONE;

         if (state == ST_IDLE && prm[1] && !s2)
            seen_low <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // A rise always takes priority over the timeout in the same cycle.
   always_comb begin
      state_nxt = state;
      ld_meas   = 1'b0;
      ld_stuck  = 1'b0;
      clr_stuck = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (rise) begin
               if (seen_low)
                  state_nxt = ST_MEASURE;
            end else if (per_cnt == TO_VAL) begin
               state_nxt = ST_STUCK;
               ld_stuck  = 1'b1;
            end
         end
         ST_MEASURE: begin
            if (rise) begin
               ld_meas = 1'b1;
            end else if (per_cnt == TO_VAL) begin
               state_nxt = ST_STUCK;
               ld_stuck  = 1'b1;
            end
         end
         ST_STUCK: begin
            if (rise) begin
               state_nxt = ST_MEASURE;
               clr_stuck = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_out  <= '0;
         high_out    <= '0;
         duty_out    <= '0;
         valid       <= 1'b0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         valid <= ld_meas | ld_stuck;
         if (ld_meas) begin
            period_out <= per_cnt;
            high_out   <= hi_cnt;
            duty_out   <= sat_duty(32'(hi_cnt));
         end else if (ld_stuck) begin
            period_out  <= '0;
            high_out    <= '0;
            duty_out    <= s2 ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
            stuck       <= 1'b1;
            stuck_level <= s2;
         end
         if (clr_stuck)
            stuck <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
// Directed bench for pwm_capture: an in-bench PWM source drives the input and
// every result is compared against hand-computed values.
module tb_pwm_capture;

   logic        clk;
   logic        rst_n;
   logic        pwm_in;
   logic [15:0] period_out;
   logic [15:0] high_out;
   logic [7:0]  duty_out;
   logic        valid;
   logic        stuck;
   logic        stuck_level;

   int n_chk  = 0;
   int n_pass = 0;

   // source controls, written only by the main stimulus thread
   bit gen_on  = 0;
   bit gen_lvl = 0;
   int nxt_hi  = 0;
   int nxt_per = 256;
   int gen_seq = 0;

   pwm_capture #(.CNT_W(16), .TIMEOUT(1024)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pwm_in      (pwm_in),
      .period_out  (period_out),
      .high_out    (high_out),
      .duty_out    (duty_out),
      .valid       (valid),
      .stuck       (stuck),
      .stuck_level (stuck_level)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   // PWM source: new high/period values take effect only at a period boundary.
   initial begin
      int cnt;
      int cur_hi;
      int cur_per;
      int seen_seq;
      cnt = 0; cur_hi = 0; cur_per = 256; seen_seq = 0;
      pwm_in = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (gen_seq != seen_seq) begin
            seen_seq = gen_seq;
            cnt = 0;
         end
         if (gen_on) begin
            if (cnt == 0) begin
               cur_hi  = nxt_hi;
               cur_per = nxt_per;
            end
            pwm_in = (cnt < cur_hi);
            cnt = (cnt + 1 >= cur_per) ? 0 : cnt + 1;
         end else begin
            pwm_in = gen_lvl;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_per"},   32'(period_out),  0);
      chk({tag, "_hi"},    32'(high_out),    0);
      chk({tag, "_duty"},  32'(duty_out),    0);
      chk({tag, "_vld"},   32'(valid),       0);
      chk({tag, "_stk"},   32'(stuck),       0);
      chk({tag, "_stlvl"}, 32'(stuck_level), 0);
   endtask

   task automatic wait_valid(input int budget, output int n, output bit got);
      n = 0;
      got = 0;
      while (!got && n < budget) begin
         @(negedge clk);
         n++;
         got = (valid === 1'b1);
      end
   endtask

   task automatic meas(input string tag, input int budget, input int exp_n,
                       input int per, input int hi, input int dty, input int stk,
                       output int n);
      bit got;
      wait_valid(budget, n, got);
      chk({tag, "_vld"}, 32'(got), 1);
      if (exp_n >= 0)
         chk({tag, "_gap"}, n, exp_n);
      chk({tag, "_per"},  32'(period_out), per);
      chk({tag, "_hi"},   32'(high_out),   hi);
      chk({tag, "_duty"}, 32'(duty_out),   dty);
      chk({tag, "_stk"},  32'(stuck),      stk);
   endtask

   task automatic gen_start(input int hi, input int per);
      nxt_hi  = hi;
      nxt_per = per;
      gen_seq++;
      gen_on  = 1;
   endtask

   initial begin
      int  n;
      bit  got;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("rst0");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // duty 64 of 256: arm on first rise, measure on the second
      gen_start(64, 256);
      meas("d64a", 700, -1, 256, 64, 64, 0, n);
      @(negedge clk);
      chk("d64_pulse", 32'(valid), 0);
      meas("d64b", 300, 255, 256, 64, 64, 0, n);

      // duty 255, then duty 1; each change lands one period later
      nxt_hi = 255;
      meas("d255a", 300, 256, 256, 64, 64, 0, n);
      meas("d255b", 300, 256, 256, 255, 255, 0, n);
      nxt_hi = 1;
      meas("d1a", 300, 256, 256, 255, 255, 0, n);
      meas("d1b", 300, 256, 256, 1, 1, 0, n);

      // constant low: stuck report 1024 cycles after the last measurement
      gen_on  = 0;
      gen_lvl = 0;
      meas("lo", 1100, 1024, 0, 0, 0, 1, n);
      chk("lo_stlvl", 32'(stuck_level), 0);
      wait_valid(2000, n, got);
      chk("lo_quiet", 32'(got), 0);
      chk("lo_hold", 32'(stuck), 1);

      // input high through reset release: no arming, stuck high after timeout
      gen_lvl = 1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("rst1");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      meas("hi", 1200, 1025, 0, 0, 255, 1, n);
      chk("hi_stlvl", 32'(stuck_level), 1);

      // 100 high / 300 low out of stuck: first rise arms, second measures
      gen_start(100, 400);
      meas("arm", 1000, -1, 400, 100, 100, 0, n);
      chk("arm_late", 32'(n > 600), 1);

      // high time above 255 saturates duty
      nxt_hi  = 280;
      nxt_per = 300;
      meas("p300a", 500, 400, 400, 100, 100, 0, n);
      meas("p300b", 400, 300, 300, 280, 255, 0, n);

      // reset mid-period with the input high
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("rst2");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      meas("post", 1000, -1, 300, 280, 255, 0, n);
      chk("post_late", 32'(n > 300), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
